// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM state
// encoding, operation codes and the counter-width helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width of a counter that must index n digit steps; never narrower than 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry adder: s = x + y + cin, cout = carry out.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic c;

    // Ripple the carry through the digit one full adder at a time.
    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit. Operands are latched on an accepted start,
// then consumed DIGIT bits per clock, LSB digit first, through a single digit
// adder. Result and flags are published together with a one-cycle done pulse
// and hold until the next completion or reset.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;       // operand A, shifted right one digit per step
    logic [WIDTH-1:0] b_q, b_d;       // operand B, shifted right one digit per step
    logic             op_q, op_d;
    logic             cy_q, cy_d;     // carry between digit steps
    logic [WIDTH-1:0] acc_q, acc_d;   // sum digits enter at the top, shift down
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] x_dig, y_dig, s_dig;
    logic             cout_dig;

    // The current digit is always the low digit of the shifting operands;
    // subtraction feeds the inverted B digit (the +1 arrives as initial carry).
    always_comb begin
        x_dig = a_q[DIGIT-1:0];
        y_dig = b_q[DIGIT-1:0] ^ {DIGIT{op_q}};
    end

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (x_dig),
        .y    (y_dig),
        .cin  (cy_q),
        .s    (s_dig),
        .cout (cout_dig)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cy_d     = cy_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cy_d    = (op == OP_SUB);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = (acc_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cy_d  = cout_dig;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // On the last step the low digit holds the operand MSBs.
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    result_d = acc_d;
                    carry_d  = cout_dig ^ op_q;
                    ovf_d    = (x_dig[DIGIT-1] == y_dig[DIGIT-1]) &&
                               (s_dig[DIGIT-1] != x_dig[DIGIT-1]);
                    zero_d   = (acc_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and result registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            cy_q     <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cy_q     <= cy_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
